// File: rtl/mdu_execute.sv
// Iterative multiply/divide execute unit. It sits beside the single-cycle ALU,
// takes one operation at a time and stalls upstream while it iterates (one
// multiplier or quotient bit per cycle). The result reaches the MEM stage
// through its own pipe register.
module mdu_execute #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [1:0]       op_in,
  input  logic [15:0]      instruction_in,
  input  logic             RegWrt_in,
  input  logic [WIDTH-1:0] A_reg,
  input  logic [WIDTH-1:0] B_reg,
  input  logic [WIDTH-1:0] WData,
  input  logic [WIDTH-1:0] Xcomp_fwd,
  input  logic [1:0]       forward_A,
  input  logic [1:0]       forward_B,
  input  logic             flush,
  output logic             stall,
  output logic [WIDTH-1:0] result_out,
  output logic [15:0]      instruction_out,
  output logic             RegWrt_out,
  output logic             valid_out
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;

  // acc_reg: upper product half / partial remainder
  // lo_reg : multiplier being shifted out / dividend shifted out, quotient shifted in
  // opb_reg: multiplicand / divisor
  logic [WIDTH-1:0] acc_reg, lo_reg, opb_reg;
  logic [1:0]       op_reg;
  logic [15:0]      instr_reg;
  logic             regwrt_reg;

  logic [WIDTH-1:0] op_a, op_b;
  logic             accept, last_iter;
  logic [WIDTH:0]   mul_sum, div_trial, div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] acc_next, lo_next, result_next;

  // Same operand forwarding as the EX stage
  always_comb begin
    case (forward_A)
      2'b01:   op_a = WData;
      2'b10:   op_a = Xcomp_fwd;
      default: op_a = A_reg;
    endcase
    case (forward_B)
      2'b01:   op_b = WData;
      2'b10:   op_b = Xcomp_fwd;
      default: op_b = B_reg;
    endcase
  end

  assign accept    = (state_reg == IDLE) && valid_in && !flush;
  assign last_iter = (state_reg == RUN) && (count_reg == LAST_CNT);
  assign stall     = accept || ((state_reg == RUN) && !last_iter);

  // One shift-add or restoring-divide step; op_reg[0] picks the high half / remainder
  always_comb begin
    mul_sum   = {1'b0, acc_reg} + (lo_reg[0] ? {1'b0, opb_reg} : {(WIDTH+1){1'b0}});
    div_trial = {acc_reg, lo_reg[WIDTH-1]};
    div_diff  = div_trial - {1'b0, opb_reg};
    div_ge    = (div_trial >= {1'b0, opb_reg});
    if (op_reg[1]) begin
      acc_next = div_ge ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0];
      lo_next  = {lo_reg[WIDTH-2:0], div_ge};
    end else begin
      acc_next = mul_sum[WIDTH:1];
      lo_next  = {mul_sum[0], lo_reg[WIDTH-1:1]};
    end
    result_next = op_reg[0] ? acc_next : lo_next;
  end

  // State and iteration counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  // Next-state logic: flush kills anything in flight
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    if (flush) begin
      state_next = IDLE;
      count_next = '0;
    end else if (state_reg == IDLE) begin
      if (valid_in) begin
        state_next = RUN;
        count_next = '0;
      end
    end else if (last_iter) begin
      state_next = IDLE;
      count_next = '0;
    end else begin
      count_next = count_reg + CNT_W'(1);
    end
  end

  // Operand capture at accept, one iteration per RUN cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg    <= '0;
      lo_reg     <= '0;
      opb_reg    <= '0;
      op_reg     <= '0;
      instr_reg  <= '0;
      regwrt_reg <= 1'b0;
    end else if (accept) begin
      acc_reg    <= '0;
      lo_reg     <= op_in[1] ? op_a : op_b;
      opb_reg    <= op_in[1] ? op_b : op_a;
      op_reg     <= op_in;
      instr_reg  <= instruction_in;
      regwrt_reg <= RegWrt_in;
    end else if (state_reg == RUN) begin
      acc_reg <= acc_next;
      lo_reg  <= lo_next;
    end
  end

  // EX/MEM pipe register; flush drops the completion but keeps the old result
  always_ff @(posedge clk) begin
    if (rst) begin
      result_out      <= '0;
      instruction_out <= '0;
      RegWrt_out      <= 1'b0;
      valid_out       <= 1'b0;
    end else if (flush) begin
      instruction_out <= '0;
      RegWrt_out      <= 1'b0;
      valid_out       <= 1'b0;
    end else if (last_iter) begin
      result_out      <= result_next;
      instruction_out <= instr_reg;
      RegWrt_out      <= regwrt_reg;
      valid_out       <= 1'b1;
    end else begin
      valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mdu_execute.sv
// Scoreboard bench for mdu_execute: the driver pushes the arithmetic result
// expected for each accepted operation, and a monitor pops and compares
// whenever valid_out is seen.
module tb_mdu_execute;
  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst, valid_in, RegWrt_in, flush;
  logic [1:0]    op_in, forward_A, forward_B;
  logic [15:0]   instruction_in;
  logic [W-1:0]  A_reg, B_reg, WData, Xcomp_fwd;
  logic          stall, RegWrt_out, valid_out;
  logic [W-1:0]  result_out;
  logic [15:0]   instruction_out;

  int n_checks = 0;
  int n_fail   = 0;
  int cycle_cnt = 0;

  typedef struct {
    logic [W-1:0] res;
    logic [15:0]  instr;
    logic         rw;
    int           cyc;
  } exp_t;
  exp_t sb[$];

  mdu_execute #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .op_in(op_in),
    .instruction_in(instruction_in), .RegWrt_in(RegWrt_in),
    .A_reg(A_reg), .B_reg(B_reg), .WData(WData), .Xcomp_fwd(Xcomp_fwd),
    .forward_A(forward_A), .forward_B(forward_B), .flush(flush),
    .stall(stall), .result_out(result_out), .instruction_out(instruction_out),
    .RegWrt_out(RegWrt_out), .valid_out(valid_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle_cnt++;

  function automatic void check(string name, longint act, longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle_cnt);
    end
  endfunction

  // Reference arithmetic
  function automatic logic [W-1:0] ref_op(logic [1:0] op, longint a, longint b);
    longint p;
    p = a * b;
    case (op)
      2'b00:   return W'(p);
      2'b01:   return W'(p >> W);
      2'b10:   return (b == 0) ? {W{1'b1}} : W'(a / b);
      default: return (b == 0) ? W'(a) : W'(a % b);
    endcase
  endfunction

  function automatic longint sel(logic [1:0] f, logic [W-1:0] r, logic [W-1:0] wd, logic [W-1:0] xf);
    return (f == 2'b01) ? longint'(wd) : (f == 2'b10) ? longint'(xf) : longint'(r);
  endfunction

  // Monitor: every completion pulse must match the oldest expectation
  always @(negedge clk) begin
    if (valid_out) begin
      if (sb.size() == 0) begin
        check("unexpected_valid_out", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result_out", result_out, e.res);
        check("instruction_out", instruction_out, e.instr);
        check("RegWrt_out", RegWrt_out, e.rw);
        check("latency_cycle", cycle_cnt, e.cyc);
        $display("done res=0x%04h instr=0x%04h rw=%0b cycle=%0d", result_out, instruction_out, RegWrt_out, cycle_cnt);
      end
    end
  end

  task automatic scramble();
    A_reg = W'($urandom); B_reg = W'($urandom);
    WData = W'($urandom); Xcomp_fwd = W'($urandom);
    forward_A = 2'($urandom); forward_B = 2'($urandom);
  endtask

  // Present at a negedge while idle; returns at the negedge of cycle W+1 (valid_in still high)
  task automatic present(logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b,
                         logic [1:0] fa, logic [1:0] fb, logic [W-1:0] wd, logic [W-1:0] xf,
                         logic [15:0] instr, logic rw, int flush_at);
    exp_t e;
    valid_in = 1'b1; op_in = op; A_reg = a; B_reg = b; forward_A = fa; forward_B = fb;
    WData = wd; Xcomp_fwd = xf; instruction_in = instr; RegWrt_in = rw;
    e.res = ref_op(op, sel(fa, a, wd, xf), sel(fb, b, wd, xf));
    e.instr = instr; e.rw = rw; e.cyc = cycle_cnt + W + 1;
    #1 check("stall_accept", stall, 1);
    if (flush_at < 0) sb.push_back(e);
    $display("issue op=%0d a=0x%04h b=0x%04h fa=%0d fb=%0d exp=0x%04h", op, a, b, fa, fb, e.res);
    for (int k = 1; k <= W; k++) begin
      @(negedge clk);
      if (k == flush_at) begin
        valid_in = 1'b0; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("stall_after_flush", stall, 0);
        check("RegWrt_after_flush", RegWrt_out, 0);
        check("instr_after_flush", instruction_out, 0);
        return;
      end
      check($sformatf("stall_c%0d", k), stall, (k == W) ? 0 : 1);
      scramble();
    end
    @(negedge clk);
  endtask

  task automatic run(logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b, logic [15:0] instr);
    present(op, a, b, 2'b00, 2'b00, '0, '0, instr, 1'b1, -1);
  endtask

  task automatic idle(int n);
    valid_in = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; valid_in = 1'b0; flush = 1'b0; op_in = '0; instruction_in = '0;
    RegWrt_in = 1'b0; A_reg = '0; B_reg = '0; WData = '0; Xcomp_fwd = '0;
    forward_A = '0; forward_B = '0;
    repeat (3) @(negedge clk);
    check("rst_result", result_out, 0);
    check("rst_valid", valid_out, 0);
    check("rst_rw", RegWrt_out, 0);
    check("rst_instr", instruction_out, 0);
    check("rst_stall", stall, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed operations
    run(2'b00, 16'h0003, 16'h0005, 16'hC0DE);
    idle(2);
    run(2'b00, 16'hFFFF, 16'hFFFF, 16'h0101);
    run(2'b01, 16'hFFFF, 16'hFFFF, 16'h0102);
    run(2'b01, 16'h8000, 16'h0002, 16'h0103);
    run(2'b10, 16'd100, 16'd7, 16'h0104);
    run(2'b11, 16'd100, 16'd7, 16'h0105);
    run(2'b10, 16'h1234, 16'h0000, 16'h0106);
    run(2'b11, 16'h1234, 16'h0000, 16'h0107);
    // Forwarding, then a back-to-back op
    present(2'b10, 16'hAAAA, 16'hAAAA, 2'b01, 2'b10, 16'd9, 16'd3, 16'h0200, 1'b1, -1);
    present(2'b00, 16'h0011, 16'h0003, 2'b00, 2'b00, '0, '0, 16'h0201, 1'b0, -1);
    idle(2);

    // Randomized operations with varied forwarding and gaps
    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] a, b;
      a = W'($urandom);
      b = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom >> $urandom_range(0, 16));
      present(2'($urandom), a, b, 2'($urandom), 2'($urandom), W'($urandom), W'($urandom),
              16'($urandom), 1'($urandom), -1);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(2);

    // Flush in cycle 5 of a DIV, then a normal MUL
    run(2'b00, 16'h0007, 16'h0009, 16'h0300);
    present(2'b10, 16'd500, 16'd3, 2'b00, 2'b00, '0, '0, 16'h0301, 1'b1, 5);
    idle(W + 3);
    check("valid_after_flush", valid_out, 0);
    run(2'b00, 16'd2, 16'd2, 16'h0302);
    idle(2);

    // Reset in cycle 8 of a MUL
    valid_in = 1'b1; op_in = 2'b00; A_reg = 16'h0123; B_reg = 16'h0045;
    forward_A = '0; forward_B = '0; instruction_in = 16'h0400; RegWrt_in = 1'b1;
    repeat (8) @(negedge clk);
    valid_in = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("midrst_result", result_out, 0);
    check("midrst_instr", instruction_out, 0);
    check("midrst_rw", RegWrt_out, 0);
    check("midrst_valid", valid_out, 0);
    check("midrst_stall", stall, 0);
    rst = 1'b0;
    @(negedge clk);
    // Flush together with valid_in: not accepted
    valid_in = 1'b1; flush = 1'b1;
    #1 check("flush_valid_stall", stall, 0);
    @(negedge clk);
    valid_in = 1'b0; flush = 1'b0;
    #1 check("flush_valid_not_run", stall, 0);
    idle(W + 3);
    check("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end
endmodule

// File: doc/mdu_execute.md
Name: mdu_execute

Overview:
- Iterative multiply/divide execute unit; sits beside the single-cycle execute ALU in the EX stage.
- Accepts one MUL/MULH/DIV/REM operation at a time and stalls upstream stages while it iterates.
- Applies the same two-source operand forwarding as the EX stage.
- Delivers the result, instruction and write-enable through its own EX/MEM pipe register.
- Data width is parametrised.

Parameters:
WIDTH, 16, operand/result width in bits; legal values are WIDTH >= 2.
CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, not overridden.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
valid_in  in  1  an MDU operation is presented this cycle
op_in  in  2  00 MUL (low half), 01 MULH (unsigned high half), 10 DIV (unsigned quotient), 11 REM (unsigned remainder)
instruction_in  in  16  instruction word, carried with the operation
RegWrt_in  in  1  register write enable, carried with the operation
A_reg  in  WIDTH  register-file operand A
B_reg  in  WIDTH  register-file operand B
WData  in  WIDTH  writeback-stage forward value
Xcomp_fwd  in  WIDTH  EX/MEM forward value
forward_A  in  2  01 selects WData, 10 selects Xcomp_fwd, otherwise A_reg
forward_B  in  2  same encoding as forward_A, applied to operand B
flush  in  1  kill any in-flight or presented operation
stall  out  1  hold the upstream pipe registers
result_out  out  WIDTH  registered result
instruction_out  out  16  registered instruction of the completed operation
RegWrt_out  out  1  registered write enable of the completed operation
valid_out  out  1  one-cycle completion pulse

Behaviour:
- Reset: synchronous, active-high on clk.
  - Clears the state to IDLE and the counter to 0.
  - Clears all internal operand/accumulator registers.
  - result_out=0, instruction_out=0, RegWrt_out=0, valid_out=0.
  - stall is combinational: it is 0 while rst is held unless valid_in=1.
- FSM states: IDLE and RUN.
- IDLE:
  - If valid_in=1 and flush=0, the operation is accepted (cycle 0).
  - Latch the forwarded operands, op_in, instruction_in and RegWrt_in; set count=0; next state RUN.
  - Otherwise remain in IDLE.
- RUN:
  - One iteration per cycle; count increments each cycle.
  - On the iteration where count==WIDTH-1, the final iteration completes and the state returns to IDLE.
  - RUN occupies cycles 1..WIDTH.
- Multiply (MUL/MULH):
  - Unsigned shift-add over a 2*WIDTH-bit product, consuming one multiplier bit per cycle, LSB first.
  - MUL returns product[WIDTH-1:0]; MULH returns product[2*WIDTH-1:WIDTH].
- Divide (DIV/REM):
  - Unsigned restoring division, producing one quotient bit per cycle, MSB first.
  - DIV returns the quotient; REM returns the remainder.
  - Divide by zero (divisor==0 at accept): quotient = all ones, remainder = dividend. No exception is raised.
- stall:
  - stall = (IDLE & valid_in & ~flush) | (RUN & count != WIDTH-1).
  - stall is therefore 1 in cycles 0..WIDTH-1 and 0 in cycle WIDTH, so upstream advances at the edge ending cycle WIDTH.
- Completion:
  - At the edge ending cycle WIDTH, result_out, instruction_out and RegWrt_out are loaded, and valid_out=1 for cycle WIDTH+1 only.
  - Latency from accept to valid_out is WIDTH+1 cycles.
  - A new operation may be accepted in cycle WIDTH+1 (back-to-back issue).
- Output hold: result_out, instruction_out and RegWrt_out hold their value until the next completion, flush or reset. valid_out=0 otherwise.
- Operand capture: operands and forwarding selects are sampled only at accept. Changes to A_reg, B_reg, WData, Xcomp_fwd or forward_* during RUN are ignored.
- Flush:
  - Synchronous, in any state; returns to IDLE and clears the counter.
  - Sets valid_out=0, RegWrt_out=0 and instruction_out=0 on the next cycle.
  - result_out is unchanged.
  - Flush in the same cycle as valid_in: the operation is not accepted and stall=0.
  - Flush in cycle WIDTH: the completion is suppressed.
- Reset mid-operation: same as flush, and additionally clears result_out.
- valid_in=1 while in RUN is ignored. Upstream is stalled, so it re-presents the operation after completion.

Test Plan:
1. WIDTH=16, MUL 0x0003*0x0005 accepted at cycle 0 -> stall=1 in cycles 0-15, stall=0 in cycle 16; valid_out=1 only in cycle 17; result_out=0x000F; RegWrt_out and instruction_out equal the inputs at accept.
2. MUL and MULH with 0xFFFF*0xFFFF -> MUL=0x0001, MULH=0xFFFE. MULH 0x8000*0x0002 -> 0x0001.
3. DIV 100/7 -> 0x000E; REM 100/7 -> 0x0002. DIV 0x1234/0 -> 0xFFFF; REM 0x1234/0 -> 0x1234.
4. Forwarding: forward_A=01 with WData=9, forward_B=10 with Xcomp_fwd=3, A_reg=B_reg=0xAAAA, op DIV -> 0x0003. Changing all operand inputs during RUN has no effect. Back-to-back second op accepted in cycle 17 completes with valid_out in cycle 34.
5. Flush asserted in cycle 5 of a DIV -> stall=0 from cycle 6, valid_out never pulses, RegWrt_out=0. A following MUL 2*2 completes normally with result 0x0004.
6. rst asserted in cycle 8 of a MUL -> all outputs 0 the next cycle, stall=0. After rst release, flush and valid_in together -> not accepted, stall=0, no valid_out.
